// File: rtl/branch_resolver_if.sv
// branch_resolver_if: branch request and branch result valid/ready channels between controller and resolver.
interface branch_resolver_if #(
    parameter int PC_W  = 9,
    parameter int IMM_W = 8
);
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_cond;
    logic [IMM_W-1:0] br_imm;
    logic [PC_W-1:0]  pc_in;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic [PC_W-1:0]  res_pc;

    modport master (
        output br_valid, br_cond, br_imm, pc_in, res_ready,
        input  br_ready, res_valid, res_taken, res_pc
    );

    modport slave (
        input  br_valid, br_cond, br_imm, pc_in, res_ready,
        output br_ready, res_valid, res_taken, res_pc
    );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: holds ALU {N,V,Z} flags and resolves branch requests into taken/next-PC results.
// Defining BRANCH_RESOLVER_FWD_EN removes the EVAL state and forwards same-edge flag loads.
module branch_resolver #(
    parameter int PC_W  = 9,
    parameter int IMM_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loads,
    input  logic [2:0] status_in,
    output logic [2:0] flags,
    branch_resolver_if.slave br
);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      flags_q;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] res_pc_q, res_pc_d;
    logic            accept;

    // flag bits: [2] N, [1] V, [0] Z
    function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
        logic lt;
        lt = f[2] ^ f[1];
        return c == 3'd0 ? 1'b1 : c == 3'd1 ? f[0] : c == 3'd2 ? ~f[0] :
               c == 3'd3 ? lt : c == 3'd4 ? (lt | f[0]) : 1'b0;
    endfunction

    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                                 input logic [IMM_W-1:0] imm, input logic t);
        return pc + PC_W'(1) + (t ? PC_W'($signed(imm)) : {PC_W{1'b0}});
    endfunction

    assign br.br_ready  = ~reset & (state_q == IDLE);
    assign accept       = br.br_valid & br.br_ready;
    assign br.res_valid = state_q == DONE;
    assign br.res_taken = taken_q;
    assign br.res_pc    = res_pc_q;
    assign flags        = flags_q;

`ifdef BRANCH_RESOLVER_FWD_EN
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        res_pc_d = res_pc_q;
        if (accept) begin
            taken_d  = cond_met(br.br_cond, loads ? status_in : flags_q);
            res_pc_d = next_pc(br.pc_in, br.br_imm, taken_d);
            state_d  = DONE;
        end else if (state_q == DONE && br.res_ready) begin
            state_d = IDLE;
        end
    end
`else
    logic [2:0]       cond_q;
    logic [IMM_W-1:0] imm_q;
    logic [PC_W-1:0]  pc_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            cond_q <= br.br_cond;
            imm_q  <= br.br_imm;
            pc_q   <= br.pc_in;
        end
    end

    // EVAL reads flags_q, which already holds any load made on the accept edge
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        res_pc_d = res_pc_q;
        if (accept) begin
            state_d = EVAL;
        end else if (state_q == EVAL) begin
            taken_d  = cond_met(cond_q, flags_q);
            res_pc_d = next_pc(pc_q, imm_q, taken_d);
            state_d  = DONE;
        end else if (state_q == DONE && br.res_ready) begin
            state_d = IDLE;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            flags_q  <= 3'b000;
            taken_q  <= 1'b0;
            res_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= loads ? status_in : flags_q;
            taken_q  <= taken_d;
            res_pc_q <= res_pc_d;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with hand-computed results for branch_resolver.
module tb_branch_resolver;
`ifdef BRANCH_RESOLVER_FWD_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic       clk;
    logic       reset;
    logic       loads;
    logic [2:0] status_in;
    logic [2:0] flags;
    int         checks;
    int         errors;

    branch_resolver_if bus ();

    branch_resolver dut (
        .clk       (clk),
        .reset     (reset),
        .loads     (loads),
        .status_in (status_in),
        .flags     (flags),
        .br        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_flags(input logic [2:0] st);
        loads     = 1'b1;
        status_in = st;
        @(posedge clk);
        #1 loads = 1'b0;
        @(negedge clk);
        chk("flags_load", flags, st);
    endtask

    // present a request, wait for its result, check latency/result, then drain it
    task automatic do_branch(input string tag, input logic [2:0] cond, input logic [7:0] imm,
                             input logic [8:0] pc, input logic ld, input logic [2:0] st,
                             input logic exp_taken, input logic [8:0] exp_pc);
        int n;
        bus.br_valid = 1'b1;
        bus.br_cond  = cond;
        bus.br_imm   = imm;
        bus.pc_in    = pc;
        loads        = ld;
        status_in    = st;
        chk({tag, "_ready"}, bus.br_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.br_valid = 1'b0;
        loads        = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 8);
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_taken"}, bus.res_taken, exp_taken);
        chk({tag, "_pc"}, bus.res_pc, exp_pc);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rdy_after"}, {bus.br_ready, bus.res_valid}, 2'b10);
    endtask

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        loads         = 1'b1;
        status_in     = 3'b111;
        bus.br_valid  = 1'b1;
        bus.br_cond   = 3'd0;
        bus.br_imm    = 8'h00;
        bus.pc_in     = 9'h000;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", flags, 3'b000);
        chk("rst_valid", bus.res_valid, 1'b0);
        chk("rst_ready", bus.br_ready, 1'b0);
        chk("rst_res", {bus.res_taken, bus.res_pc}, 10'h000);
        reset        = 1'b0;
        loads        = 1'b0;
        bus.br_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.br_ready, 1'b1);
        chk("post_rst_valid", bus.res_valid, 1'b0);

        set_flags(3'b001);
        do_branch("beq", 3'd1, 8'h05, 9'h010, 1'b0, 3'b000, 1'b1, 9'h016);
        set_flags(3'b100);
        do_branch("blt_wrap", 3'd3, 8'hFD, 9'h000, 1'b0, 3'b000, 1'b1, 9'h1FE);
        set_flags(3'b000);
        do_branch("hazard_bne", 3'd2, 8'h07, 9'h020, 1'b1, 3'b001, 1'b0, 9'h021);
        chk("hazard_flags", flags, 3'b001);
        do_branch("b_back", 3'd0, 8'h80, 9'h100, 1'b0, 3'b000, 1'b1, 9'h081);
        do_branch("b_wrap", 3'd0, 8'h00, 9'h1FF, 1'b0, 3'b000, 1'b1, 9'h000);
        set_flags(3'b110);
        do_branch("ble_nt", 3'd4, 8'h10, 9'h040, 1'b0, 3'b000, 1'b0, 9'h041);
        do_branch("bne_t", 3'd2, 8'h10, 9'h040, 1'b0, 3'b000, 1'b1, 9'h051);
        do_branch("blt_nt", 3'd3, 8'h10, 9'h040, 1'b0, 3'b000, 1'b0, 9'h041);
        set_flags(3'b111);
        do_branch("ble_t", 3'd4, 8'h10, 9'h040, 1'b0, 3'b000, 1'b1, 9'h051);
        do_branch("beq_t7", 3'd1, 8'hFF, 9'h040, 1'b0, 3'b000, 1'b1, 9'h040);
        do_branch("rsv", 3'd7, 8'h10, 9'h0A0, 1'b0, 3'b000, 1'b0, 9'h0A1);
        do_branch("rsv5", 3'd5, 8'h10, 9'h0A0, 1'b0, 3'b000, 1'b0, 9'h0A1);

        // backpressure: result must hold while flags churn and a new request waits
        set_flags(3'b000);
        bus.br_valid = 1'b1;
        bus.br_cond  = 3'd1;
        bus.br_imm   = 8'h02;
        bus.pc_in    = 9'h050;
        @(posedge clk);
        #1;
        bus.br_cond = 3'd0;
        bus.pc_in   = 9'h123;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 8);
        chk("bp_lat", n, LAT);
        for (int i = 0; i < 4; i++) begin
            loads     = 1'b1;
            status_in = 3'(i + 1);
            chk("bp_hold", {bus.res_valid, bus.br_ready, bus.res_taken, bus.res_pc}, {3'b100, 9'h051});
            @(negedge clk);
        end
        chk("bp_hold_end", {bus.res_valid, bus.br_ready, bus.res_taken, bus.res_pc}, {3'b100, 9'h051});
        loads         = 1'b0;
        bus.br_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {bus.br_ready, bus.res_valid}, 2'b10);
        chk("bp_flags", flags, 3'b100);

        // reset just after accept: discarded, no result
        set_flags(3'b001);
        bus.br_valid = 1'b1;
        bus.br_cond  = 3'd0;
        bus.pc_in    = 9'h070;
        @(posedge clk);
        #1;
        bus.br_valid = 1'b0;
        reset        = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_eval", {bus.res_valid, bus.br_ready, flags}, {2'b01, 3'b000});
        end

        // reset while DONE, with a competing load
        bus.br_valid = 1'b1;
        @(posedge clk);
        #1 bus.br_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 8);
        chk("rst_done_pre", bus.res_valid, 1'b1);
        reset     = 1'b1;
        loads     = 1'b1;
        status_in = 3'b111;
        @(negedge clk);
        chk("rst_done", {bus.res_valid, bus.br_ready, flags}, {2'b00, 3'b000});
        reset = 1'b0;
        loads = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_done_idle", {bus.res_valid, bus.br_ready, flags}, {2'b01, 3'b000});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
